data_cache: RTL and testbench

//  Responder for the CPU data-memory interface (READ/WRITE, ADDRESS, WRITEDATA, READDATA, BUSY_WAIT).

---
 rtl/data_cache.sv | 129 ++++++++++++
 tb/tb_data_cache.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache with 4-byte lines.
// Misses stall the CPU through optional write-back, then a block refill.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSY_WAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSY_WAIT
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW    = 6 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_MEMRD,
    S_UPDATE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       data_q [LINES];
  logic [31:0]       data_d [LINES];
  logic [TW-1:0]     tag_q  [LINES];
  logic [TW-1:0]     tag_d  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [31:0]       fill_q, fill_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TW-1:0]         tag;
  logic [4:0]            boff;
  logic                  hit;
  logic                  req;

  assign idx  = ADDRESS[1+INDEX_BITS:2];
  assign tag  = ADDRESS[7:2+INDEX_BITS];
  assign boff = {ADDRESS[1:0], 3'b000};
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign req  = READ | WRITE;

  assign READDATA = data_q[idx][boff +: 8];

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    fill_d        = fill_q;
    BUSY_WAIT     = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    unique case (state_q)
      S_IDLE: begin
        BUSY_WAIT = req && !hit && !RESET;
        if (req && hit) begin
          if (WRITE) begin
            data_d[idx][boff +: 8] = WRITEDATA;
            dirty_d[idx] = 1'b1;
          end
        end else if (req) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_MEMRD;
        end
      end
      S_WB: begin
        BUSY_WAIT     = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = data_q[idx];
        if (!MEM_BUSY_WAIT) state_d = S_MEMRD;
      end
      S_MEMRD: begin
        BUSY_WAIT   = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[7:2];
        if (!MEM_BUSY_WAIT) begin
          fill_d  = MEM_READDATA;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        BUSY_WAIT    = 1'b1;
        data_d[idx]  = fill_q;
        tag_d[idx]   = tag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      fill_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      fill_q  <= fill_d;
      for (int i = 0; i < LINES; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a flat byte-memory reference plus
// per-line valid/dirty/tag bookkeeping predicts data and stall timing.
module tb_data_cache;

  localparam int IB = 3;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSY_WAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSY_WAIT;

  data_cache #(.INDEX_BITS(IB)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSY_WAIT     (BUSY_WAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSY_WAIT (MEM_BUSY_WAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // main memory: each request is busy for `stall` cycles, then completes
  logic [31:0] mem [64];
  bit          mem_init;
  int          stall = 5;
  int          cnt;

  assign MEM_BUSY_WAIT = (MEM_READ | MEM_WRITE) && (cnt != stall);
  assign MEM_READDATA  = mem[MEM_ADDRESS];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= 0;
      if (!mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= $urandom;
        mem[0]   <= 32'hDDCCBBAA;
        mem_init <= 1'b1;
      end
    end else if (MEM_READ | MEM_WRITE) begin
      if (cnt == stall) begin
        cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  always @(negedge CLK)
    if (!RESET) check("mem_excl", MEM_READ & MEM_WRITE, 0);

  // reference: CPU-visible byte memory and cache line bookkeeping
  logic [7:0] flat [256];
  bit         rvalid [8];
  bit         rdirty [8];
  int         rtag [8];

  function automatic int lidx(input logic [7:0] a);
    return (int'(a) >> 2) & ((1 << IB) - 1);
  endfunction

  function automatic int ltag(input logic [7:0] a);
    return int'(a) >> (2 + IB);
  endfunction

  task automatic model_reset();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      rvalid[i] = 0;
      rdirty[i] = 0;
      rtag[i]   = 0;
    end
    for (int a = 0; a < 256; a++) begin
      w = mem[a / 4];
      flat[a] = w[(a % 4) * 8 +: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    READ  = 1'b0;
    WRITE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic cpu_op(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
    int i, t, nwb, tot, g, base;
    bit miss, wb, eb, emr, emw;
    logic [5:0]  vaddr, ema;
    logic [31:0] vdata;
    i     = lidx(a);
    t     = ltag(a);
    miss  = !(rvalid[i] && rtag[i] == t);
    wb    = miss && rdirty[i];
    nwb   = wb ? stall + 1 : 0;
    tot   = miss ? 1 + nwb + stall + 1 + 1 : 0;
    vaddr = 6'((rtag[i] << IB) | i);
    base  = int'(vaddr) * 4;
    vdata = {flat[base+3], flat[base+2], flat[base+1], flat[base]};
    @(negedge CLK);
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = a;
    WRITEDATA = d;
    #1;
    for (int k = 0; k <= tot; k++) begin
      eb  = (k < tot);
      emr = 0;
      emw = 0;
      ema = '0;
      if (k >= 1 && k <= nwb) begin
        emw = 1;
        ema = vaddr;
      end else if (k >= 1 && k > nwb && k <= nwb + stall + 1) begin
        emr = 1;
        ema = a[7:2];
      end
      check("busy", BUSY_WAIT, eb);
      check("mem_ctl", {MEM_READ, MEM_WRITE, MEM_ADDRESS}, {emr, emw, ema});
      if (k == 1 && wb) check("wb_data", MEM_WRITEDATA, vdata);
      if (k < tot) begin
        @(negedge CLK);
        #1;
      end
    end
    g = 0;
    while (BUSY_WAIT && g < 200) begin
      @(negedge CLK);
      #1;
      g++;
    end
    if (g == 200) check("stall_timeout", 1, 0);
    if (!wr) check("rdata", READDATA, flat[a]);
    if (miss) begin
      rvalid[i] = 1;
      rtag[i]   = t;
      rdirty[i] = 0;
    end
    if (wr) begin
      flat[a]   = d;
      rdirty[i] = 1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    logic       wr, rd;
    RESET     = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = '0;
    WRITEDATA = '0;
    do_reset();
    #1;
    check("rst_busy", BUSY_WAIT, 0);
    check("rst_mem", {MEM_READ, MEM_WRITE, MEM_ADDRESS}, 0);
    check("rst_wdata", MEM_WRITEDATA, 0);
    check("rst_rdata", READDATA, 0);

    cpu_op(1, 0, 8'h02, 8'h00);
    check("t2_rd02", READDATA, 8'hCC);
    cpu_op(1, 0, 8'h03, 8'h00);
    check("t2_rd03", READDATA, 8'hDD);
    cpu_op(0, 1, 8'h01, 8'h55);
    cpu_op(1, 0, 8'h01, 8'h00);
    check("t3_rd01", READDATA, 8'h55);
    cpu_op(1, 0, 8'h20, 8'h00);
    check("t4_wb_mem", mem[0], 32'hDDCC55AA);

    stall = 10;
    cpu_op(1, 0, 8'h44, 8'h00);
    stall = 5;

    @(negedge CLK);
    READ    = 1'b1;
    WRITE   = 1'b0;
    ADDRESS = 8'h02;
    repeat (3) @(negedge CLK);
    #1;
    check("t6_pre_mrd", MEM_READ, 1);
    RESET = 1'b1;
    #1;
    check("t6_rst_mrd", MEM_READ, 0);
    check("t6_rst_mwr", MEM_WRITE, 0);
    check("t6_rst_busy", BUSY_WAIT, 0);
    check("t6_rst_rdata", READDATA, 0);
    @(negedge CLK);
    RESET = 1'b0;
    READ  = 1'b0;
    model_reset();
    cpu_op(1, 0, 8'h02, 8'h00);
    check("t6_rd02", READDATA, 8'hCC);

    for (int n = 0; n < 300; n++) begin
      stall = $urandom_range(0, 6);
      a     = 8'($urandom_range(0, 127));
      wr    = 1'($urandom_range(0, 1));
      rd    = !wr || ($urandom_range(0, 9) == 0);
      cpu_op(rd, wr, a, 8'($urandom));
    end

    @(negedge CLK);
    READ  = 1'b0;
    WRITE = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
